// File: rtl/hazard_unit.sv
// ID/EX hazard controller: load-use bubbles, branch squash, memory freeze.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
//
// Ports:
//  clk, rstn                 clock, async active-low reset
//  regReadNum0/1, useRs1/2   source registers of the ID instruction
//  exRegWriteNum, exMemRead,
//  exRegWrite                destination info of the EX instruction
//  branchTaken               EX redirect this cycle
//  memBusy                   data memory not ready
//  pcStall, ifidStall        hold PC / IF/ID
//  ifidFlush, idexFlush      NOP into IF/ID / ID/EX
//  pipeFreeze                hold every pipeline register
//  stallCnt, flushCnt        perf counters (zero unless enabled)
module hazard_unit #(
  parameter int REG_NUM_WIDTH     = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [REG_NUM_WIDTH-1:0] regReadNum0,
  input  logic [REG_NUM_WIDTH-1:0] regReadNum1,
  input  logic                     useRs1,
  input  logic                     useRs2,
  input  logic [REG_NUM_WIDTH-1:0] exRegWriteNum,
  input  logic                     exMemRead,
  input  logic                     exRegWrite,
  input  logic                     branchTaken,
  input  logic                     memBusy,
  output logic                     pcStall,
  output logic                     ifidStall,
  output logic                     ifidFlush,
  output logic                     idexFlush,
  output logic                     pipeFreeze,
  output logic [CNT_WIDTH-1:0]     stallCnt,
  output logic [CNT_WIDTH-1:0]     flushCnt
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  localparam logic [2:0] LdInit = 3'(LOAD_STALL_CYCLES - 1);
  localparam bit MultiStall = (LOAD_STALL_CYCLES > 1);

  state_t     state;
  state_t     stateNxt;
  logic [2:0] cnt;
  logic [2:0] cntNxt;

  logic rs1Hit;
  logic rs2Hit;
  logic hazLU;

  logic pcStallC;
  logic ifidStallC;
  logic ifidFlushC;
  logic idexFlushC;
  logic pipeFreezeC;
  logic stallInc;
  logic flushInc;

  // Only a load that really writes a non-zero rd can create a hazard.
  assign rs1Hit = useRs1 && (regReadNum0 == exRegWriteNum);
  assign rs2Hit = useRs2 && (regReadNum1 == exRegWriteNum);
  assign hazLU  = exMemRead && exRegWrite &&
                  (exRegWriteNum != '0) && (rs1Hit || rs2Hit);

  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    pcStallC    = 1'b0;
    ifidStallC  = 1'b0;
    ifidFlushC  = 1'b0;
    idexFlushC  = 1'b0;
    pipeFreezeC = 1'b0;
    stallInc    = 1'b0;
    flushInc    = 1'b0;
    if (memBusy) begin
      // Whole pipe holds; decisions wait for memory to release.
      pipeFreezeC = 1'b1;
      pcStallC    = 1'b1;
      ifidStallC  = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (branchTaken) begin
            // ID slot is wrong-path, so its hazard is moot.
            ifidFlushC = 1'b1;
            idexFlushC = 1'b1;
            flushInc   = 1'b1;
            stateNxt   = FLUSH;
          end else if (hazLU) begin
            pcStallC   = 1'b1;
            ifidStallC = 1'b1;
            idexFlushC = 1'b1;
            stallInc   = 1'b1;
            if (MultiStall) begin
              cntNxt   = LdInit;
              stateNxt = LDSTALL;
            end
          end
        end
        LDSTALL: begin
          // EX holds a bubble here, so nothing new is detected.
          pcStallC   = 1'b1;
          ifidStallC = 1'b1;
          idexFlushC = 1'b1;
          stallInc   = 1'b1;
          if (cnt <= 3'd1) begin
            cntNxt   = 3'd0;
            stateNxt = RUN;
          end else begin
            cntNxt = cnt - 3'd1;
          end
        end
        FLUSH: begin
          stateNxt = RUN;
        end
        default: begin
          cntNxt   = 3'd0;
          stateNxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  // Reset forces quiet outputs even while inputs still look hazardous.
  assign pcStall    = rstn & pcStallC;
  assign ifidStall  = rstn & ifidStallC;
  assign ifidFlush  = rstn & ifidFlushC;
  assign idexFlush  = rstn & idexFlushC;
  assign pipeFreeze = rstn & pipeFreezeC;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallInc) stallCnt <= stallCnt + 1'b1;
      if (flushInc) flushCnt <= flushCnt + 1'b1;
    end
  end
`else
  logic unusedInc;
  assign unusedInc = stallInc ^ flushInc;
  assign stallCnt  = '0;
  assign flushCnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (1 and 2 bubble cycles)
// share stimulus; per-cycle expectations go through a scoreboard queue.
module tb_hazard_unit;

  typedef struct {
    logic [4:0] e1;
    logic [4:0] e2;
  } exp_t;

  localparam logic [4:0] Z     = 5'b00000;
  localparam logic [4:0] STALL = 5'b01101;
  localparam logic [4:0] BR    = 5'b00011;
  localparam logic [4:0] FRZ   = 5'b11100;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, rw, br, mb;

  logic pcS1, ifS1, ifF1, idF1, frz1;
  logic pcS2, ifS2, ifF2, idF2, frz2;
  logic [31:0] sc1, fc1, sc2, fc2;
  logic [4:0]  o1, o2;

  assign o1 = {frz1, pcS1, ifS1, ifF1, idF1};
  assign o2 = {frz2, pcS2, ifS2, ifF2, idF2};

  exp_t sb[$];
  int   nCmp = 0;
  int   nErr = 0;
  int   s1 = 0;
  int   s2 = 0;
  int   fl = 0;

  hazard_unit #(.LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .rstn(rstn),
    .regReadNum0(rs1), .regReadNum1(rs2),
    .useRs1(u1), .useRs2(u2),
    .exRegWriteNum(rd), .exMemRead(mr), .exRegWrite(rw),
    .branchTaken(br), .memBusy(mb),
    .pcStall(pcS1), .ifidStall(ifS1),
    .ifidFlush(ifF1), .idexFlush(idF1),
    .pipeFreeze(frz1),
    .stallCnt(sc1), .flushCnt(fc1)
  );

  hazard_unit #(.LOAD_STALL_CYCLES(2)) u_dut2 (
    .clk(clk), .rstn(rstn),
    .regReadNum0(rs1), .regReadNum1(rs2),
    .useRs1(u1), .useRs2(u2),
    .exRegWriteNum(rd), .exMemRead(mr), .exRegWrite(rw),
    .branchTaken(br), .memBusy(mb),
    .pcStall(pcS2), .ifidStall(ifS2),
    .ifidFlush(ifF2), .idexFlush(idF2),
    .pipeFreeze(frz2),
    .stallCnt(sc2), .flushCnt(fc2)
  );

  task automatic drv(input logic [4:0] a, input logic [4:0] b,
                     input logic ua, input logic ub,
                     input logic [4:0] d, input logic m,
                     input logic w, input logic bt, input logic bz);
    rs1 = a; rs2 = b; u1 = ua; u2 = ub;
    rd = d; mr = m; rw = w; br = bt; mb = bz;
  endtask

  task automatic test_reset();
    exp_t e;
    rstn = 1'b0;
    drv(5, 0, 1, 0, 5, 1, 1, 1, 1);
    @(posedge clk); #1;
    nCmp++;
    if (o1 !== Z || o2 !== Z || sc1 !== 0 || sc2 !== 0 ||
        fc1 !== 0 || fc2 !== 0) begin
      nErr++;
      $display("FAIL reset_hold: got %b/%b cnt %0d %0d %0d %0d want 0",
               o1, o2, sc1, sc2, fc1, fc2);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    e = '{Z, Z};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    nCmp++;
    if (o1 !== e.e1 || o2 !== e.e2) begin
      nErr++;
      $display("FAIL reset_release: got %b/%b want %b/%b",
               o1, o2, e.e1, e.e2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drv(5, 0, 1, 0, 5, 1, 1, 0, 0); e = '{STALL, STALL}; end
        1: begin drv(5, 0, 1, 0, 0, 0, 0, 0, 0); e = '{Z, STALL}; end
        default: begin drv(5, 0, 1, 0, 0, 0, 0, 0, 0); e = '{Z, Z}; end
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      nCmp++;
      if (o1 !== e.e1 || o2 !== e.e2) begin
        nErr++;
        $display("FAIL load_use c%0d: got %b/%b want %b/%b",
                 c, o1, o2, e.e1, e.e2);
      end
      @(posedge clk); #1;
    end
    s1 += 1; s2 += 2;
    nCmp++;
    if (sc1 !== (PERF ? s1 : 0) || sc2 !== (PERF ? s2 : 0)) begin
      nErr++;
      $display("FAIL load_use_cnt: got %0d/%0d want %0d/%0d",
               sc1, sc2, PERF ? s1 : 0, PERF ? s2 : 0);
    end
  endtask

  task automatic test_no_hazard();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: begin drv(0, 0, 1, 0, 0, 1, 1, 0, 0); e = '{Z, Z}; end
        1: begin drv(3, 5, 1, 0, 5, 1, 1, 0, 0); e = '{Z, Z}; end
        2: begin drv(5, 0, 1, 0, 5, 1, 0, 0, 0); e = '{Z, Z}; end
        3: begin drv(3, 5, 1, 1, 5, 1, 1, 0, 0); e = '{STALL, STALL}; end
        4: begin drv(3, 5, 1, 1, 0, 0, 0, 0, 0); e = '{Z, STALL}; end
        default: begin drv(3, 5, 1, 1, 0, 0, 0, 0, 0); e = '{Z, Z}; end
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      nCmp++;
      if (o1 !== e.e1 || o2 !== e.e2) begin
        nErr++;
        $display("FAIL no_hazard c%0d: got %b/%b want %b/%b",
                 c, o1, o2, e.e1, e.e2);
      end
      @(posedge clk); #1;
    end
    s1 += 1; s2 += 2;
  endtask

  task automatic test_branch();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drv(5, 0, 1, 0, 5, 1, 1, 1, 0); e = '{BR, BR}; end
        1: begin drv(5, 0, 1, 0, 5, 1, 1, 1, 0); e = '{Z, Z}; end
        default: begin drv(0, 0, 0, 0, 0, 0, 0, 0, 0); e = '{Z, Z}; end
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      nCmp++;
      if (o1 !== e.e1 || o2 !== e.e2) begin
        nErr++;
        $display("FAIL branch c%0d: got %b/%b want %b/%b",
                 c, o1, o2, e.e1, e.e2);
      end
      @(posedge clk); #1;
    end
    fl += 1;
    nCmp++;
    if (fc1 !== (PERF ? fl : 0) || fc2 !== (PERF ? fl : 0)) begin
      nErr++;
      $display("FAIL branch_cnt: got %0d/%0d want %0d",
               fc1, fc2, PERF ? fl : 0);
    end
  endtask

  task automatic test_mem_busy();
    exp_t e;
    for (int c = 0; c < 9; c++) begin
      case (c)
        0: begin drv(5, 0, 1, 0, 5, 1, 1, 0, 0); e = '{STALL, STALL}; end
        1, 2, 3: begin
          drv(5, 0, 1, 0, 0, 0, 0, 0, 1); e = '{FRZ, FRZ};
        end
        4: begin drv(5, 0, 1, 0, 0, 0, 0, 0, 0); e = '{Z, STALL}; end
        5: begin drv(0, 0, 0, 0, 0, 0, 0, 0, 0); e = '{Z, Z}; end
        6: begin drv(5, 0, 1, 0, 5, 1, 1, 1, 1); e = '{FRZ, FRZ}; end
        7: begin drv(5, 0, 1, 0, 5, 1, 1, 1, 0); e = '{BR, BR}; end
        default: begin drv(0, 0, 0, 0, 0, 0, 0, 0, 0); e = '{Z, Z}; end
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      nCmp++;
      if (o1 !== e.e1 || o2 !== e.e2) begin
        nErr++;
        $display("FAIL mem_busy c%0d: got %b/%b want %b/%b",
                 c, o1, o2, e.e1, e.e2);
      end
      @(posedge clk); #1;
    end
    s1 += 1; s2 += 2; fl += 1;
    nCmp++;
    if (sc1 !== (PERF ? s1 : 0) || sc2 !== (PERF ? s2 : 0) ||
        fc2 !== (PERF ? fl : 0)) begin
      nErr++;
      $display("FAIL mem_busy_cnt: got %0d/%0d/%0d want %0d/%0d/%0d",
               sc1, sc2, fc2, PERF ? s1 : 0, PERF ? s2 : 0, PERF ? fl : 0);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin drv(5, 0, 1, 0, 5, 1, 1, 0, 0); e = '{STALL, STALL}; end
        1, 2: begin
          drv(0, 6, 0, 1, 6, 1, 1, 0, 0); e = '{STALL, STALL};
        end
        3: begin drv(0, 6, 0, 1, 0, 0, 0, 0, 0); e = '{Z, STALL}; end
        default: begin drv(0, 0, 0, 0, 0, 0, 0, 0, 0); e = '{Z, Z}; end
      endcase
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      nCmp++;
      if (o1 !== e.e1 || o2 !== e.e2) begin
        nErr++;
        $display("FAIL back_to_back c%0d: got %b/%b want %b/%b",
                 c, o1, o2, e.e1, e.e2);
      end
      @(posedge clk); #1;
    end
    s1 += 3; s2 += 4;
    nCmp++;
    if (sc1 !== (PERF ? s1 : 0) || sc2 !== (PERF ? s2 : 0)) begin
      nErr++;
      $display("FAIL back_to_back_cnt: got %0d/%0d want %0d/%0d",
               sc1, sc2, PERF ? s1 : 0, PERF ? s2 : 0);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    drv(5, 0, 1, 0, 5, 1, 1, 0, 0);
    e = '{STALL, STALL};
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    nCmp++;
    if (o1 !== e.e1 || o2 !== e.e2) begin
      nErr++;
      $display("FAIL reset_mid_pre: got %b/%b want %b/%b",
               o1, o2, e.e1, e.e2);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    nCmp++;
    if (o1 !== Z || o2 !== Z || sc1 !== 0 || sc2 !== 0 ||
        fc1 !== 0 || fc2 !== 0) begin
      nErr++;
      $display("FAIL reset_mid_async: got %b/%b cnt %0d %0d %0d %0d want 0",
               o1, o2, sc1, sc2, fc1, fc2);
    end
    s1 = 0; s2 = 0; fl = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    drv(5, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      e = '{Z, Z};
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      nCmp++;
      if (o1 !== e.e1 || o2 !== e.e2 || sc2 !== 0) begin
        nErr++;
        $display("FAIL reset_mid_post c%0d: got %b/%b cnt %0d want %b/%b 0",
                 c, o1, o2, sc2, e.e1, e.e2);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rstn = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_mem_busy();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
